oled_spi_scheduler: RTL and testbench
=====================================

OLED_SPI_SCHEDULER -- requirements
Module: oled_spi_scheduler

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, giving clk cycles per SCLK half-period (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have ports cmd_valid in 1, cmd_data in 8, cmd_last in 1, cmd_ready out 1: command byte stream; cmd_last marks the final byte of a command packet.
REQ-005 SHALL have ports pix_valid in 1, pix_data in 16 (RGB565), pix_ready out 1: pixel word stream.
REQ-006 SHALL have ports oled_cs out 1 (active-low select), oled_sclk out 1, oled_mosi out 1, oled_dc out 1 (0 = command, 1 = pixel data).
REQ-007 SHALL have port busy, out, 1, high whenever the FSM is not IDLE.

Function
REQ-008 SHALL share one SPI link between the command requester and the pixel requester; a grant covers one whole command packet (through the cmd_last byte) or one pixel word (2 bytes).
REQ-009 Arbitration SHALL happen only in IDLE; single requester wins; if both are valid, the requester not granted last wins (round-robin); last-grant resets to pixel, so the first conflict goes to command.
REQ-010 cmd_ready / pix_ready SHALL be combinational, high only in a load slot for the granted requester; a transfer occurs when valid and ready are both high at a clk edge.
REQ-011 Pixel word SHALL be latched whole on acceptance and sent high byte [15:8] first; each byte SHALL be sent MSB first.
REQ-012 FSM states: IDLE, SETUP, SHIFT, WAIT, HOLD, DESELECT.
REQ-013 IDLE->SETUP on acceptance: the next cycle oled_cs=0, oled_dc set per grant, oled_sclk=0, oled_mosi=byte MSB; SETUP lasts CLK_DIV cycles.
REQ-014 SHIFT: each bit occupies 2*CLK_DIV cycles: oled_sclk=1 in the first half, 0 in the second; oled_mosi changes only at bit-period start, so it is stable across each falling edge, where the panel samples.
REQ-015 At end of a byte, if more bytes remain in the grant and the next byte is available (pixel low byte always; command byte when cmd_valid), the next byte's first bit SHALL follow with no gap.
REQ-016 Mid-packet with cmd_valid low: WAIT, holding oled_cs=0, oled_sclk=0, oled_dc unchanged; cmd_ready stays high; the next bit starts the cycle after acceptance.
REQ-017 After the final byte: HOLD for CLK_DIV cycles with oled_cs=0, then DESELECT with oled_cs=1 for 2*CLK_DIV cycles, then IDLE.
REQ-018 oled_dc SHALL stay constant from SETUP through HOLD.
REQ-019 Inputs changing while not ready SHALL be ignored; cmd_last on a pixel grant is irrelevant.
REQ-020 All SPI outputs SHALL be registered, glitch-free.

Reset
REQ-021 While rst=1, on the next edge: FSM=IDLE, oled_cs=1, oled_sclk=0, oled_mosi=0, oled_dc=0, busy=0, cmd_ready=0, pix_ready=0, counters=0, last-grant=pixel.
REQ-022 Reset mid-transfer SHALL abort the transaction immediately, with no further SCLK edges; the partial byte is discarded, not resent.

Structure
REQ-023 Package oled_pkg SHALL hold the FSM state enum, DC_CMD/DC_DATA constants and the RGB565 width constant.
REQ-024 Sub-module oled_spi_shifter SHALL own the half-period divider, bit counter and shift register (load/start in, byte_done out); oled_spi_scheduler owns arbitration and the FSM.

Verification
REQ-025 CLK_DIV=2, command 0xAF with cmd_last -> oled_cs low 2+32+2=36 cycles, dc=0, falling-edge samples 1,0,1,0,1,1,1,1, then cs high 4 cycles.
REQ-026 Pixel 0xF800 -> one cs frame, dc=1, 16 falling-edge samples F8 then 00, pix_ready exactly one cycle.
REQ-027 After reset, cmd and pix valid together -> command packet first; with both still pending afterwards, the pixel wins next (alternation).
REQ-028 3-byte command packet, cmd_valid dropped 10 cycles before byte 2 -> cs stays low, sclk held 0 during WAIT, no extra edges, byte 2 resumes one cycle after acceptance.
REQ-029 rst asserted mid-bit 5 of a pixel -> next edge cs=1, sclk=0, busy=0; a following pixel transfers correctly.

Source files
------------

// File: rtl/oled_pkg.sv
// oled_pkg: shared FSM states, D/C levels and pixel width for the OLED SPI scheduler
package oled_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, HOLD, DESELECT} state_t;
    localparam logic DC_CMD = 1'b0;
    localparam logic DC_DATA = 1'b1;
    localparam int RGB565_W = 16;
endpackage

// File: rtl/oled_spi_shifter.sv
// oled_spi_shifter: MSB-first byte serialiser with SCLK half-period divider
module oled_spi_shifter #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       start,
    input  logic [7:0] data,
    output logic       sclk,
    output logic       mosi,
    output logic       byte_done
);
    logic [7:0] div;
    logic [7:0] sreg;
    logic [2:0] bit_cnt;
    logic       run;
    logic       half_end;
    assign half_end = run && div == 8'(CLK_DIV - 1);
    assign byte_done = half_end && !sclk && bit_cnt == 3'd7;
    assign mosi = sreg[7];
    // advance SCLK halves; a load/start in the same cycle chains the next byte with no gap
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            sreg <= '0;
            bit_cnt <= '0;
            run <= 1'b0;
            sclk <= 1'b0;
        end else begin
            if (half_end) begin
                div <= '0;
                if (sclk) sclk <= 1'b0;
                else if (bit_cnt == 3'd7) run <= 1'b0;
                else begin
                    sclk <= 1'b1;
                    bit_cnt <= bit_cnt + 3'd1;
                    sreg <= {sreg[6:0], 1'b0};
                end
            end else if (run) div <= div + 8'd1;
            if (load) begin
                sreg <= data;
                bit_cnt <= '0;
            end
            if (start) begin
                run <= 1'b1;
                sclk <= 1'b1;
                div <= '0;
            end
        end
    end
endmodule

// File: rtl/oled_spi_scheduler.sv
// oled_spi_scheduler: round-robin sharing of one OLED SPI link between command packets and pixel words
module oled_spi_scheduler
    import oled_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    input  logic [7:0]          cmd_data,
    input  logic                cmd_last,
    output logic                cmd_ready,
    input  logic                pix_valid,
    input  logic [RGB565_W-1:0] pix_data,
    output logic                pix_ready,
    output logic                oled_cs,
    output logic                oled_sclk,
    output logic                oled_mosi,
    output logic                oled_dc,
    output logic                busy
);
    state_t     state, nxt;
    logic [8:0] cnt;
    logic       last_pix, last_q, second;
    logic [7:0] pix_lo, sh_data;
    logic       load, start, byte_done, g_cmd, g_pix;
    assign g_cmd = cmd_valid && (!pix_valid || last_pix);
    assign g_pix = pix_valid && !g_cmd;
    oled_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk(clk), .rst(rst), .load(load), .start(start), .data(sh_data),
        .sclk(oled_sclk), .mosi(oled_mosi), .byte_done(byte_done)
    );
    // next state, ready handshakes and shifter load/start for the current grant
    always_comb begin
        nxt = state;
        load = 1'b0;
        start = 1'b0;
        sh_data = cmd_data;
        cmd_ready = 1'b0;
        pix_ready = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !rst && g_cmd;
                pix_ready = !rst && g_pix;
                load = cmd_ready || pix_ready;
                sh_data = pix_ready ? pix_data[15:8] : cmd_data;
                nxt = load ? SETUP : IDLE;
            end
            SETUP: begin
                start = cnt == 9'(CLK_DIV - 1);
                nxt = start ? SHIFT : SETUP;
            end
            SHIFT: if (byte_done) begin
                if (oled_dc == DC_DATA) begin
                    load = !second;
                    start = !second;
                    sh_data = pix_lo;
                    nxt = second ? HOLD : SHIFT;
                end else begin
                    cmd_ready = !last_q;
                    load = !last_q && cmd_valid;
                    start = load;
                    nxt = last_q ? HOLD : (cmd_valid ? SHIFT : WAIT);
                end
            end
            WAIT: begin
                cmd_ready = 1'b1;
                load = cmd_valid;
                start = cmd_valid;
                nxt = cmd_valid ? SHIFT : WAIT;
            end
            HOLD: nxt = cnt == 9'(CLK_DIV - 1) ? DESELECT : HOLD;
            DESELECT: nxt = cnt == 9'(2 * CLK_DIV - 1) ? IDLE : DESELECT;
            default: nxt = IDLE;
        endcase
    end
    // state, phase counter, registered CS/DC/busy and per-grant bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            oled_cs <= 1'b1;
            oled_dc <= DC_CMD;
            busy <= 1'b0;
            last_pix <= 1'b1;
            last_q <= 1'b0;
            second <= 1'b0;
            pix_lo <= '0;
        end else begin
            state <= nxt;
            cnt <= nxt != state ? '0 : cnt + 9'd1;
            oled_cs <= nxt == IDLE || nxt == DESELECT;
            busy <= nxt != IDLE;
            if (cmd_ready && cmd_valid) last_q <= cmd_last;
            if (pix_ready && pix_valid) begin
                pix_lo <= pix_data[7:0];
                second <= 1'b0;
            end
            if (state == IDLE && nxt == SETUP) begin
                oled_dc <= pix_ready ? DC_DATA : DC_CMD;
                last_pix <= pix_ready;
            end
            if (state == SHIFT && byte_done && oled_dc == DC_DATA) second <= 1'b1;
        end
    end
endmodule

// File: tb/tb_oled_spi_scheduler.sv
// tb_oled_spi_scheduler: table, corner-case and randomized checks of the OLED SPI scheduler
module tb_oled_spi_scheduler;
    logic clk = 0, rst = 1;
    logic cmd_valid = 0, cmd_last = 0, cmd_ready;
    logic [7:0] cmd_data = 0;
    logic pix_valid = 0, pix_ready;
    logic [15:0] pix_data = 0;
    logic oled_cs, oled_sclk, oled_mosi, oled_dc, busy;
    int tests = 0, fails = 0, rd = 0;

    typedef struct packed {
        logic dc;
        logic [31:0] len, nbits, cs_rises, desel;
        logic [63:0] bits;
        logic bad;
    } frame_t;
    typedef struct {
        logic is_pix;
        logic [15:0] data;
        logic [63:0] bits;
        int nbits;
        int len;
    } vec_t;

    frame_t frames[$];
    frame_t cur = '0;
    logic p_sclk = 0, p_cs = 1, p_busy = 0, p_mosi = 0;
    int stray = 0, pix_rdy_cnt = 0;

    oled_spi_scheduler #(.CLK_DIV(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_last(cmd_last), .cmd_ready(cmd_ready),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .oled_cs(oled_cs), .oled_sclk(oled_sclk), .oled_mosi(oled_mosi), .oled_dc(oled_dc), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    // panel-side monitor: records each busy period as a frame of falling-edge samples
    always @(negedge clk) begin
        p_sclk <= oled_sclk;
        p_cs <= oled_cs;
        p_busy <= busy;
        p_mosi <= oled_mosi;
        if (pix_ready) pix_rdy_cnt <= pix_rdy_cnt + 1;
        if (oled_cs && oled_sclk) stray <= stray + 1;
        if (busy && !p_busy) begin
            cur <= '0;
            cur.dc <= oled_dc;
            cur.len <= 1;
        end else if (busy) begin
            if (!oled_cs) cur.len <= cur.len + 1;
            if (oled_cs) cur.desel <= cur.desel + 1;
            if (!p_cs && oled_cs) cur.cs_rises <= cur.cs_rises + 1;
            if (!oled_cs && oled_dc !== cur.dc) cur.bad <= 1'b1;
            if (p_sclk && !oled_sclk) begin
                cur.bits <= {cur.bits[62:0], oled_mosi};
                cur.nbits <= cur.nbits + 1;
                if (p_mosi !== oled_mosi) cur.bad <= 1'b1;
            end
        end
        if (p_busy && !busy) frames.push_back(cur);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [7:0] d, input logic l);
        int n = 0;
        @(posedge clk); #1;
        cmd_valid = 1; cmd_data = d; cmd_last = l;
        @(negedge clk);
        while (!cmd_ready && n < 5000) begin n++; @(negedge clk); end
        if (n >= 5000) begin tests++; fails++; $display("FAIL cmd_accept: got no cmd_ready, expected handshake"); end
        @(posedge clk); #1;
        cmd_valid = 0; cmd_data = 8'($urandom); cmd_last = 1'($urandom);
    endtask

    task automatic push_pix(input logic [15:0] d);
        int n = 0;
        @(posedge clk); #1;
        pix_valid = 1; pix_data = d;
        @(negedge clk);
        while (!pix_ready && n < 5000) begin n++; @(negedge clk); end
        if (n >= 5000) begin tests++; fails++; $display("FAIL pix_accept: got no pix_ready, expected handshake"); end
        @(posedge clk); #1;
        pix_valid = 0; pix_data = 16'($urandom);
    endtask

    task automatic next_frame(output frame_t f);
        int n = 0;
        while (frames.size() <= rd && n < 3000) begin @(negedge clk); n++; end
        if (frames.size() > rd) begin f = frames[rd]; rd++; end
        else begin f = '0; tests++; fails++; $display("FAIL frame_timeout: got none, expected a frame"); end
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst = 1;
        @(posedge clk); #1; rst = 0;
        @(negedge clk); @(negedge clk);
        rd = frames.size();
    endtask

    initial begin
        vec_t tbl[7];
        frame_t f;
        int r0, nb, n;
        logic [63:0] eb;
        logic [15:0] d16;
        logic [7:0] d8;
        logic edc, exp_cmd, lg_pix;
        int en;
        tbl[0] = '{1'b0, 16'h00AF, 64'hAF, 8, 36};
        tbl[1] = '{1'b1, 16'hF800, 64'hF800, 16, 68};
        tbl[2] = '{1'b0, 16'h0000, 64'h00, 8, 36};
        tbl[3] = '{1'b1, 16'h1234, 64'h1234, 16, 68};
        tbl[4] = '{1'b0, 16'h00FF, 64'hFF, 8, 36};
        tbl[5] = '{1'b1, 16'hFFFF, 64'hFFFF, 16, 68};
        tbl[6] = '{1'b1, 16'h0001, 64'h0001, 16, 68};

        cmd_valid = 1; pix_valid = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs", oled_cs, 1);
        chk("rst_sclk", oled_sclk, 0);
        chk("rst_mosi", oled_mosi, 0);
        chk("rst_dc", oled_dc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_pix_ready", pix_ready, 0);
        cmd_valid = 0; pix_valid = 0; rst = 0;

        for (int i = 0; i < 7; i++) begin
            r0 = pix_rdy_cnt;
            if (tbl[i].is_pix) push_pix(tbl[i].data);
            else push_cmd(tbl[i].data[7:0], 1'b1);
            next_frame(f);
            chk("tbl_dc", f.dc, tbl[i].is_pix);
            chk("tbl_bits", f.bits, tbl[i].bits);
            chk("tbl_nbits", f.nbits, tbl[i].nbits);
            chk("tbl_cs_low_len", f.len, tbl[i].len);
            chk("tbl_deselect_len", f.desel, 4);
            chk("tbl_cs_rises", f.cs_rises, 1);
            chk("tbl_dc_mosi_stable", f.bad, 0);
            chk("tbl_pix_ready_cycles", pix_rdy_cnt - r0, tbl[i].is_pix ? 1 : 0);
        end

        push_cmd(8'h3C, 1'b0);
        repeat (44) @(negedge clk);
        chk("wait_cs", oled_cs, 0);
        chk("wait_sclk", oled_sclk, 0);
        chk("wait_cmd_ready", cmd_ready, 1);
        chk("wait_dc", oled_dc, 0);
        push_cmd(8'h96, 1'b0);
        chk("wait_resume_sclk", oled_sclk, 1);
        push_cmd(8'h5A, 1'b1);
        next_frame(f);
        chk("wait_bits", f.bits, 64'h3C965A);
        chk("wait_nbits", f.nbits, 24);
        chk("wait_cs_rises", f.cs_rises, 1);
        chk("wait_len", f.len, 111);
        chk("wait_stable", f.bad, 0);

        do_reset();
        @(posedge clk); #1;
        cmd_valid = 1; cmd_data = 8'hC3; cmd_last = 1; pix_valid = 1; pix_data = 16'h0F0F;
        lg_pix = 1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            @(negedge clk);
            while (!cmd_ready && !pix_ready && n < 5000) begin n++; @(negedge clk); end
            exp_cmd = lg_pix;
            chk("rr_grant", {cmd_ready, pix_ready}, exp_cmd ? 2'b10 : 2'b01);
            lg_pix = !exp_cmd;
            @(posedge clk); #1;
        end
        cmd_valid = 0; pix_valid = 0;
        lg_pix = 1;
        for (int g = 0; g < 4; g++) begin
            next_frame(f);
            chk("rr_frame_dc", f.dc, lg_pix ? 0 : 1);
            chk("rr_frame_bits", f.bits, lg_pix ? 64'hC3 : 64'h0F0F);
            lg_pix = !lg_pix;
        end

        push_pix(16'hA5C3);
        repeat (19) @(posedge clk);
        #1;
        chk("abort_pre_busy", busy, 1);
        chk("abort_pre_sclk", oled_sclk, 1);
        rst = 1;
        @(posedge clk); #1;
        chk("abort_cs", oled_cs, 1);
        chk("abort_sclk", oled_sclk, 0);
        chk("abort_busy", busy, 0);
        chk("abort_mosi", oled_mosi, 0);
        rst = 0;
        @(negedge clk); @(negedge clk);
        rd = frames.size();
        push_pix(16'h5A3C);
        next_frame(f);
        chk("abort_after_bits", f.bits, 64'h5A3C);
        chk("abort_after_nbits", f.nbits, 16);
        chk("abort_after_len", f.len, 68);

        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                d16 = 16'($urandom);
                push_pix(d16);
                edc = 1; eb = 64'(d16); en = 16;
            end else begin
                nb = $urandom_range(1, 3);
                edc = 0; eb = '0; en = 0;
                for (int k = 0; k < nb; k++) begin
                    d8 = 8'($urandom);
                    push_cmd(d8, k == nb - 1);
                    eb = {eb[55:0], d8};
                    en += 8;
                    repeat ($urandom_range(0, 40)) @(posedge clk);
                end
            end
            next_frame(f);
            chk("rand_dc", f.dc, edc);
            chk("rand_bits", f.bits, eb);
            chk("rand_nbits", f.nbits, en);
            chk("rand_cs_rises", f.cs_rises, 1);
            chk("rand_stable", f.bad, 0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        chk("stray_sclk_while_deselected", stray, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
